fnd_scan_decoder: RTL
=====================

Name: fnd_scan_decoder

Overview:
- Receive-side counterpart of the FND scan driver: watches the multiplexed 7-segment bus (fnd_com/fnd_data) and reconstructs the four displayed digits plus decimal points.
- Used as an on-chip loopback monitor for the watch/stopwatch display path, and as the bench-side checker for the display output.
- Qualifies each scan slot by a stability window, decodes segment patterns to BCD and publishes complete 4-digit frames with error and staleness flags.

Parameters:
- STABLE_CYCLES, 16: cycles {fnd_com, fnd_data} must be unchanged before a slot is sampled (range 2..255).
- TIMEOUT_CYCLES, 2_000_000: cycles without a published frame before stale asserts.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-low.
- fnd_data  in  8  segments, active-low, {dp,g,f,e,d,c,b,a}; same-clock-domain source.
- fnd_com  in  4  digit commons, active-low; bit0 = rightmost digit.
- digits  out  16  BCD {d3,d2,d1,d0}; d0 = fnd_com[0] position.
- dp_on  out  4  decoded decimal points, active-high, bit n = digit n.
- frame_valid  out  1  one-cycle pulse when digits/dp_on update.
- err  out  2  sticky until reset; bit0 = bad segment pattern, bit1 = bad common pattern.
- stale  out  1  high when no frame has been published for TIMEOUT_CYCLES.

Behaviour:
- Reset (rst=0, asynchronous): digits=0, dp_on=0, frame_valid=0, err=0, stale=0. FSM goes to IDLE. Stability and timeout counters clear. seen mask and shadow registers clear.
- Input stage: fnd_com/fnd_data registered once. All following logic uses the registered copy.
- Stability counter: clears to 0 when the registered value differs from the previous cycle. Otherwise it increments, saturating at STABLE_CYCLES. A sample event fires in the single cycle the counter reaches STABLE_CYCLES-1, i.e. at most once per stable period.
- At a sample event, by common pattern:
  - Exactly one common low: idx = that bit position.
  - All commons high: ignore, no flag.
  - More than one common low: set err[1], store nothing.
- Segment decode of data[6:0] (active-low):
  - 40→0, 79→1, 24→2, 30→3, 19→4, 12→5, 02→6, 78→7, 00→8, 10→9.
  - 7F (blank) → 4'hF, legal.
  - Anything else → 4'hE and set err[0].
- Store: shadow[idx] = code, shadow_dp[idx] = ~data[7], seen[idx] = 1. Re-sampling a slot before the frame completes overwrites it (latest wins).
- FSM:
  - IDLE→COLLECT on the first stored sample.
  - COLLECT→PUBLISH in the cycle after a store makes seen=4'b1111.
  - PUBLISH (one cycle): digits<=shadow, dp_on<=shadow_dp, frame_valid=1, seen<=0. Then →COLLECT.
- Latency: frame_valid is high 2 cycles after the completing sample event. A sample event arriving during PUBLISH is still stored and counted toward the next frame.
- Timeout counter: clears on frame_valid, otherwise increments, saturating. stale=1 while the count ≥ TIMEOUT_CYCLES. stale clears in the same cycle as frame_valid.
- Reset mid-collect discards the partial frame. The next publish requires all four slots sampled again.
- Counter widths: $clog2 of the respective parameter +1. No wrap-around permitted.

Decomposition:
- Package fnd_pkg holds:
  - segment pattern constants SEG_0..SEG_9 and SEG_BLANK;
  - code constants CODE_BLANK=4'hF and CODE_ERR=4'hE;
  - FSM state encoding IDLE/COLLECT/PUBLISH.
- One combinational sub-module, fnd_seg_decode: 7-bit pattern in → 4-bit code and invalid flag out. Shared with any future display checker.

Test Plan (STABLE_CYCLES=16, TIMEOUT_CYCLES=1000):
- Scan com 1110/F9, 1101/A4, 1011/B0, 0111/99, each held 20 cycles → exactly one frame_valid; digits=16'h4321, dp_on=0, err=0.
- Same scan but 1101 data=24 (dp on), plus one slot held only 10 cycles before the full 20-cycle pass → short slot never sampled; digits=16'h4321, dp_on=4'b0010.
- Slot 1011 with data=C1 held 20 cycles, then complete scan → err=2'b01 sticky; digits[11:8]=4'hE; err remains after later clean frames.
- com=1100 data=C0 held 20 cycles → err[1]=1, seen unchanged, no frame_valid from that slot.
- Publish one frame, then hold com=1111 for 1000 cycles → stale=1 at cycle 1000. Next complete scan → stale=0 with frame_valid.
- Pull rst low after two slots sampled → all outputs 0 immediately. Release, scan remaining two slots only → no frame_valid until all four are resampled.

Source files
------------

// File: rtl/fnd_pkg.sv
// Shared constants for the FND scan decoder: segment patterns, codes, FSM states.
package fnd_pkg;

    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned SEG_W      = 7;
    localparam int unsigned CODE_W     = 4;

    // Active-low segment patterns {g,f,e,d,c,b,a}
    localparam logic [SEG_W-1:0] SEG_0     = 7'h40;
    localparam logic [SEG_W-1:0] SEG_1     = 7'h79;
    localparam logic [SEG_W-1:0] SEG_2     = 7'h24;
    localparam logic [SEG_W-1:0] SEG_3     = 7'h30;
    localparam logic [SEG_W-1:0] SEG_4     = 7'h19;
    localparam logic [SEG_W-1:0] SEG_5     = 7'h12;
    localparam logic [SEG_W-1:0] SEG_6     = 7'h02;
    localparam logic [SEG_W-1:0] SEG_7     = 7'h78;
    localparam logic [SEG_W-1:0] SEG_8     = 7'h00;
    localparam logic [SEG_W-1:0] SEG_9     = 7'h10;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

    localparam logic [CODE_W-1:0] CODE_BLANK = 4'hF;
    localparam logic [CODE_W-1:0] CODE_ERR   = 4'hE;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        PUBLISH = 2'd2
    } state_t;

endpackage

// File: rtl/fnd_seg_decode.sv
// Combinational 7-segment (active-low) to BCD decoder with an invalid-pattern flag.
module fnd_seg_decode
    import fnd_pkg::*;
(
    input  logic [SEG_W-1:0]  seg,
    output logic [CODE_W-1:0] code,
    output logic              invalid
);

    // Map each legal pattern to its code; anything else is flagged.
    always_comb begin
        code    = CODE_ERR;
        invalid = 1'b0;
        case (seg)
            SEG_0:     code = 4'd0;
            SEG_1:     code = 4'd1;
            SEG_2:     code = 4'd2;
            SEG_3:     code = 4'd3;
            SEG_4:     code = 4'd4;
            SEG_5:     code = 4'd5;
            SEG_6:     code = 4'd6;
            SEG_7:     code = 4'd7;
            SEG_8:     code = 4'd8;
            SEG_9:     code = 4'd9;
            SEG_BLANK: code = CODE_BLANK;
            default:   invalid = 1'b1;
        endcase
    end

endmodule

// File: rtl/fnd_scan_decoder.sv
// Monitors a multiplexed FND bus and reconstructs 4-digit frames with error/stale flags.
module fnd_scan_decoder
    import fnd_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES  = 16,
    parameter int unsigned TIMEOUT_CYCLES = 2_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  fnd_data,
    input  logic [3:0]  fnd_com,
    output logic [15:0] digits,
    output logic [3:0]  dp_on,
    output logic        frame_valid,
    output logic [1:0]  err,
    output logic        stale
);

    localparam int unsigned SW = $clog2(STABLE_CYCLES) + 1;
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [SW-1:0] SAMPLE_AT   = SW'(STABLE_CYCLES - 1);
    localparam logic [SW-1:0] STABLE_MAX  = SW'(STABLE_CYCLES);
    localparam logic [TW-1:0] TIMEOUT_MAX = TW'(TIMEOUT_CYCLES);

    logic [3:0]               com_q, com_p;
    logic [7:0]               data_q, data_p;
    logic [SW-1:0]            stab_cnt;
    logic [TW-1:0]            to_cnt;
    logic [TW-1:0]            to_nxt_c;
    state_t                   state, state_nxt;
    logic [3:0][CODE_W-1:0]   shadow;
    logic [3:0]               shadow_dp;
    logic [3:0]               seen, seen_nxt_c;
    logic                     sample_c, single_c, multi_c, store_c, pub_c, bad_c;
    logic [1:0]               idx_c;
    logic [CODE_W-1:0]        code_c;

    fnd_seg_decode u_dec (
        .seg     (data_p[6:0]),
        .code    (code_c),
        .invalid (bad_c)
    );

    // Input register, one-cycle history and stability counter; bus idles all-high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            com_q    <= 4'hF;
            data_q   <= 8'hFF;
            com_p    <= 4'hF;
            data_p   <= 8'hFF;
            stab_cnt <= '0;
        end else begin
            com_q  <= fnd_com;
            data_q <= fnd_data;
            com_p  <= com_q;
            data_p <= data_q;
            if ({com_q, data_q} != {com_p, data_p}) begin
                stab_cnt <= '0;
            end else if (stab_cnt < STABLE_MAX) begin
                stab_cnt <= stab_cnt + SW'(1);
            end
        end
    end

    assign sample_c = (stab_cnt == SAMPLE_AT);

    // Classify the common pattern of the stable slot.
    always_comb begin
        single_c = 1'b0;
        multi_c  = 1'b0;
        idx_c    = 2'd0;
        case (com_p)
            4'b1110: begin single_c = 1'b1; idx_c = 2'd0; end
            4'b1101: begin single_c = 1'b1; idx_c = 2'd1; end
            4'b1011: begin single_c = 1'b1; idx_c = 2'd2; end
            4'b0111: begin single_c = 1'b1; idx_c = 2'd3; end
            4'b1111: ;
            default: multi_c = 1'b1;
        endcase
    end

    assign store_c = sample_c & single_c;

    // Next state, publish strobe, next seen mask and next timeout count.
    always_comb begin
        state_nxt  = state;
        pub_c      = 1'b0;
        seen_nxt_c = seen;
        to_nxt_c   = to_cnt;
        case (state)
            IDLE:    if (store_c) state_nxt = COLLECT;
            COLLECT: if (seen == 4'hF) begin
                state_nxt = PUBLISH;
                pub_c     = 1'b1;
            end
            PUBLISH: state_nxt = COLLECT;
            default: state_nxt = IDLE;
        endcase
        if (pub_c) seen_nxt_c = 4'h0;
        if (store_c) seen_nxt_c[idx_c] = 1'b1;
        if (pub_c) begin
            to_nxt_c = '0;
        end else if (to_cnt < TIMEOUT_MAX) begin
            to_nxt_c = to_cnt + TW'(1);
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Shadow slots, seen mask and sticky error flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shadow    <= '0;
            shadow_dp <= '0;
            seen      <= '0;
            err       <= '0;
        end else begin
            seen <= seen_nxt_c;
            if (store_c) begin
                shadow[idx_c]    <= code_c;
                shadow_dp[idx_c] <= ~data_p[7];
            end
            if (store_c && bad_c)   err[0] <= 1'b1;
            if (sample_c && multi_c) err[1] <= 1'b1;
        end
    end

    // Published frame, strobe and staleness tracking.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            digits      <= '0;
            dp_on       <= '0;
            frame_valid <= 1'b0;
            to_cnt      <= '0;
            stale       <= 1'b0;
        end else begin
            frame_valid <= pub_c;
            to_cnt      <= to_nxt_c;
            stale       <= (to_nxt_c >= TIMEOUT_MAX);
            if (pub_c) begin
                digits <= shadow;
                dp_on  <= shadow_dp;
            end
        end
    end

endmodule
